// File: rtl/filter_seq.sv
// filter_seq: sequencer for a WIN x WIN window filter. For every output pixel
// it loads the address register and image window columns (FETCH), then steps
// the filter load stages (FILT), and walks pixX/pixY across the frame.
// All state updates on the falling edge of clk; rst is async active-low.
// Optional build macro FILTER_SEQ_CONT_EN: free-running frames (last pixel
// goes straight back to FETCH at (0,0)); undefined returns to IDLE and waits
// for start.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; all strobes low, busy low
// FETCH | step k = 0..WIN: address load (k<WIN) and window column load (k>=1)
// FILT  | stage s = 0..FSTG-1: filter stage load; last stage completes pixel
module filter_seq #(
  parameter int WIN   = 3,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int FSTG  = 3,
  localparam int SW = $clog2(WIN + 2),
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stall,
  output logic          ldAddr,
  output logic [SW-1:0] selAddr,
  output logic          ldImage,
  output logic [SW-1:0] selImage,
  output logic          ldFilter,
  output logic [2:0]    selFilter,
  output logic [XW-1:0] pixX,
  output logic [YW-1:0] pixY,
  output logic          busy,
  output logic          done,
  output logic          frameDone
);

  localparam int KW = $clog2(WIN + 1);
  localparam logic [KW-1:0] K_LAST = KW'(WIN);
  localparam logic [2:0]    S_LAST = 3'(FSTG - 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FILT  = 2'd2
  } state_t;

`ifdef FILTER_SEQ_CONT_EN
  localparam state_t ST_WRAP = ST_FETCH;
`else
  localparam state_t ST_WRAP = ST_IDLE;
`endif

  state_t        state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [2:0]    s, s_nxt;
  logic [XW-1:0] pix_x, pix_x_nxt;
  logic [YW-1:0] pix_y, pix_y_nxt;
  logic          last_col, last_row, last_px;

  assign last_col = (pix_x == X_LAST);
  assign last_row = (pix_y == Y_LAST);
  assign last_px  = last_col && last_row;
  assign pixX     = pix_x;
  assign pixY     = pix_y;

  // state, step/stage counters and pixel position registers
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      k     <= '0;
      s     <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      s     <= s_nxt;
      pix_x <= pix_x_nxt;
      pix_y <= pix_y_nxt;
    end
  end

  // next-state: stall freezes everything in FETCH/FILT so the step repeats
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    s_nxt     = s;
    pix_x_nxt = pix_x;
    pix_y_nxt = pix_y;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_FETCH;
          k_nxt     = '0;
          s_nxt     = '0;
          pix_x_nxt = '0;
          pix_y_nxt = '0;
        end
      end
      ST_FETCH: begin
        if (!stall) begin
          if (k == K_LAST) begin
            state_nxt = ST_FILT;
            k_nxt     = '0;
            s_nxt     = '0;
          end else begin
            k_nxt = k + 1'b1;
          end
        end
      end
      ST_FILT: begin
        if (!stall) begin
          if (s == S_LAST) begin
            s_nxt = '0;
            k_nxt = '0;
            if (last_col) begin
              pix_x_nxt = '0;
              pix_y_nxt = last_row ? '0 : pix_y + 1'b1;
            end else begin
              pix_x_nxt = pix_x + 1'b1;
            end
            state_nxt = last_px ? ST_WRAP : ST_FETCH;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        k_nxt     = '0;
        s_nxt     = '0;
        pix_x_nxt = '0;
        pix_y_nxt = '0;
      end
    endcase
  end

  // outputs: strobes and selects decoded from state/counters, gated by stall
  always_comb begin
    ldAddr    = 1'b0;
    selAddr   = '0;
    ldImage   = 1'b0;
    selImage  = '0;
    ldFilter  = 1'b0;
    selFilter = '0;
    busy      = 1'b0;
    done      = 1'b0;
    frameDone = 1'b0;
    case (state)
      ST_FETCH: begin
        busy = 1'b1;
        if (!stall) begin
          if (k != K_LAST) begin
            ldAddr  = 1'b1;
            selAddr = SW'(k) + 1'b1;
          end
          if (k != '0) begin
            ldImage  = 1'b1;
            selImage = SW'(k);
          end
        end
      end
      ST_FILT: begin
        busy = 1'b1;
        if (!stall) begin
          ldFilter  = 1'b1;
          selFilter = s + 3'd1;
          if (s == S_LAST) begin
            done      = 1'b1;
            frameDone = last_px;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_filter_seq.sv
// Bench for filter_seq: two instances (WIN=3 4x2 frame, WIN=5 2x2 frame)
// share start/stall/rst. A frame-level reference model turns a step index
// into the expected output vector; the stimulus pushes one expectation per
// cycle and a monitor pops and compares on the rising edge (mid-cycle).
`timescale 1ns/1ps
module tb_filter_seq;

  localparam int A_WIN = 3, A_FSTG = 3, A_W = 4, A_H = 2;
  localparam int B_WIN = 5, B_FSTG = 3, B_W = 2, B_H = 2;
  localparam int A_SW = $clog2(A_WIN + 2), B_SW = $clog2(B_WIN + 2);
  localparam int A_XW = $clog2(A_W), A_YW = $clog2(A_H);
  localparam int B_XW = $clog2(B_W), B_YW = $clog2(B_H);

  typedef struct packed {
    logic       ld_addr;
    logic [3:0] sel_addr;
    logic       ld_image;
    logic [3:0] sel_image;
    logic       ld_filter;
    logic [2:0] sel_filter;
    logic [7:0] x;
    logic [7:0] y;
    logic       busy;
    logic       done;
    logic       frame_done;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic            a_ldAddr, a_ldImage, a_ldFilter, a_busy, a_done, a_frameDone;
  logic [A_SW-1:0] a_selAddr, a_selImage;
  logic [2:0]      a_selFilter;
  logic [A_XW-1:0] a_pixX;
  logic [A_YW-1:0] a_pixY;
  logic            b_ldAddr, b_ldImage, b_ldFilter, b_busy, b_done, b_frameDone;
  logic [B_SW-1:0] b_selAddr, b_selImage;
  logic [2:0]      b_selFilter;
  logic [B_XW-1:0] b_pixX;
  logic [B_YW-1:0] b_pixY;

  filter_seq #(.WIN(A_WIN), .IMG_W(A_W), .IMG_H(A_H), .FSTG(A_FSTG)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .ldAddr(a_ldAddr), .selAddr(a_selAddr), .ldImage(a_ldImage), .selImage(a_selImage),
    .ldFilter(a_ldFilter), .selFilter(a_selFilter), .pixX(a_pixX), .pixY(a_pixY),
    .busy(a_busy), .done(a_done), .frameDone(a_frameDone)
  );

  filter_seq #(.WIN(B_WIN), .IMG_W(B_W), .IMG_H(B_H), .FSTG(B_FSTG)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .ldAddr(b_ldAddr), .selAddr(b_selAddr), .ldImage(b_ldImage), .selImage(b_selImage),
    .ldFilter(b_ldFilter), .selFilter(b_selFilter), .pixX(b_pixX), .pixY(b_pixY),
    .busy(b_busy), .done(b_done), .frameDone(b_frameDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_a = 0, fd_a = 0, done_b = 0;
  bit mon_en = 1'b0;
  bit act[2];
  int pos[2];
  step_t exp_a[$];
  step_t exp_b[$];

  // expected outputs for step idx of a frame, from the sequencing rules
  function automatic step_t mk_step(input int win, input int fstg, input int w,
                                    input int h, input int idx);
    step_t e;
    int per, p, c;
    e = '0;
    per = win + 1 + fstg;
    p = idx / per;
    c = idx % per;
    e.x = 8'(p % w);
    e.y = 8'(p / w);
    e.busy = 1'b1;
    if (c <= win) begin
      if (c < win) begin e.ld_addr = 1'b1; e.sel_addr = 4'(c + 1); end
      if (c >= 1)  begin e.ld_image = 1'b1; e.sel_image = 4'(c); end
    end else begin
      e.ld_filter = 1'b1;
      e.sel_filter = 3'(c - win);
      if (c == per - 1) begin
        e.done = 1'b1;
        e.frame_done = (p == w * h - 1);
      end
    end
    return e;
  endfunction

  task automatic model_step(input int inst, input logic st, input logic sl, output step_t e);
    int win, fstg, w, h, len;
    win  = (inst == 0) ? A_WIN : B_WIN;
    fstg = (inst == 0) ? A_FSTG : B_FSTG;
    w    = (inst == 0) ? A_W : B_W;
    h    = (inst == 0) ? A_H : B_H;
    len  = w * h * (win + 1 + fstg);
    e = '0;
    if (!act[inst]) begin
      if (st) begin act[inst] = 1'b1; pos[inst] = 0; end
    end else begin
      e = mk_step(win, fstg, w, h, pos[inst]);
      if (sl) begin
        e.ld_addr = 1'b0; e.sel_addr = '0; e.ld_image = 1'b0; e.sel_image = '0;
        e.ld_filter = 1'b0; e.sel_filter = '0; e.done = 1'b0; e.frame_done = 1'b0;
      end else begin
        pos[inst]++;
        if (pos[inst] == len) begin
          pos[inst] = 0;
`ifndef FILTER_SEQ_CONT_EN
          act[inst] = 1'b0;
`endif
        end
      end
    end
  endtask

  task automatic cycle(input logic st, input logic sl);
    step_t ea, eb;
    @(negedge clk); #1;
    rst = 1'b1; start = st; stall = sl;
    model_step(0, st, sl, ea);
    model_step(1, st, sl, eb);
    exp_a.push_back(ea);
    exp_b.push_back(eb);
    mon_en = 1'b1;
  endtask

  task automatic reset_cycle();
    @(negedge clk); #1;
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0; pos[0] = 0; pos[1] = 0;
    exp_a.push_back('0);
    exp_b.push_back('0);
    mon_en = 1'b1;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_ldFilter !== 1'b0 || a_done !== 1'b0 || b_busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_immediate t=%0t got a_busy=%b a_ldFilter=%b a_done=%b b_busy=%b exp all 0",
               $time, a_busy, a_ldFilter, a_done, b_busy);
    end
  endtask

  task automatic run_until_idle(input int bound, input int stall_pct, input int start_pct);
    int n = 0;
    while ((act[0] || act[1]) && n < bound) begin
      cycle(($urandom_range(0, 99) < start_pct), ($urandom_range(0, 99) < stall_pct));
      n++;
    end
`ifndef FILTER_SEQ_CONT_EN
    checks++;
    if (act[0] || act[1]) begin
      failures++;
      $display("FAIL idle_timeout got still_busy after %0d cycles exp idle", n);
    end
`endif
    cycle(1'b0, 1'b0);
  endtask

  task automatic check_count(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  step_t ga, gb, ea_m, eb_m;

  // monitor: compare both instances against the queued expectation mid-cycle
  always @(posedge clk) begin
    if (mon_en) begin
      cyc++;
      ga = '0;
      ga.ld_addr = a_ldAddr; ga.sel_addr = 4'(a_selAddr);
      ga.ld_image = a_ldImage; ga.sel_image = 4'(a_selImage);
      ga.ld_filter = a_ldFilter; ga.sel_filter = a_selFilter;
      ga.x = 8'(a_pixX); ga.y = 8'(a_pixY);
      ga.busy = a_busy; ga.done = a_done; ga.frame_done = a_frameDone;
      gb = '0;
      gb.ld_addr = b_ldAddr; gb.sel_addr = 4'(b_selAddr);
      gb.ld_image = b_ldImage; gb.sel_image = 4'(b_selImage);
      gb.ld_filter = b_ldFilter; gb.sel_filter = b_selFilter;
      gb.x = 8'(b_pixX); gb.y = 8'(b_pixY);
      gb.busy = b_busy; gb.done = b_done; gb.frame_done = b_frameDone;
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_underflow cyc=%0d got=%h exp=none", cyc, ga);
      end else begin
        ea_m = exp_a.pop_front();
        if (ga !== ea_m) begin
          failures++;
          $display("FAIL a_outputs cyc=%0d got=%h exp=%h", cyc, ga, ea_m);
        end
      end
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_underflow cyc=%0d got=%h exp=none", cyc, gb);
      end else begin
        eb_m = exp_b.pop_front();
        if (gb !== eb_m) begin
          failures++;
          $display("FAIL b_outputs cyc=%0d got=%h exp=%h", cyc, gb, eb_m);
        end
      end
      if (a_done) done_a++;
      if (a_frameDone) fd_a++;
      if (b_done) done_b++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=no_finish exp=finish_before_%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    act[0] = 1'b0; act[1] = 1'b0; pos[0] = 0; pos[1] = 0;
    #2 rst = 1'b0;
    repeat (3) reset_cycle();

    // idle with stall toggling: nothing may happen without start
    for (int i = 0; i < 4; i++) cycle(1'b0, i[0]);

    // single clean frame
    done_a = 0; fd_a = 0; done_b = 0;
    cycle(1'b1, 1'b0);
    run_until_idle(400, 0, 0);
`ifndef FILTER_SEQ_CONT_EN
    check_count("a_frame_done_count", done_a, A_W * A_H);
    check_count("a_frame_framedone_count", fd_a, 1);
    check_count("b_frame_done_count", done_b, B_W * B_H);
`endif

    // stall for 3 cycles on FETCH k=2 of the first pixel
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 100 && pos[0] != 2; i++) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    run_until_idle(400, 0, 0);

    // randomized frames with random stalls and start pokes while busy
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'($urandom_range(0, 1)));
      cycle(1'b1, 1'b0);
      run_until_idle(800, 25, 10);
    end

    // reset during FILT s=1 of pixel (2,1), then quiet until start
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 200 && pos[0] != 47; i++) cycle(1'b0, 1'b0);
    repeat (2) reset_cycle();
    repeat (4) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    run_until_idle(400, 0, 0);

    // start held high: one frame per start sampled in IDLE
    fd_a = 0;
    for (int i = 0; i < 2 * A_W * A_H * (A_WIN + 1 + A_FSTG) + 2; i++) cycle(1'b1, 1'b0);
    run_until_idle(400, 0, 0);
`ifndef FILTER_SEQ_CONT_EN
    check_count("a_start_held_frames", fd_a, 2);
`endif

    repeat (2) cycle(1'b0, 1'b0);
    @(negedge clk);
    check_count("queue_drained", exp_a.size() + exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
